// File: rtl/bpred_pkg.sv
// Shared constants and types for the branch prediction/resolution unit.
// Optional statistics outputs are enabled with BPRED_STATS_EN.
package bpred_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_J    = 2'b01;
    localparam logic [1:0] PCSRC_BR   = 2'b10;
    localparam logic [1:0] PCSRC_JR   = 2'b11;

    // weakly not taken
    localparam int CTR_INIT = 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/bpred_if.sv
// Fetch-lookup and execute-resolve signal bundle of bpred_unit.
// Statistics outputs exist only when BPRED_STATS_EN is defined.
interface bpred_if #(
    parameter int DATA_W = 32
);
    logic              ready;
    logic              f_valid;
    logic [DATA_W-1:0] f_pc;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [5:0]        ex_op;
    logic [5:0]        ex_func;
    logic [4:0]        ex_rt_field;
    logic [25:0]       ex_index;
    logic [DATA_W-1:0] ex_rs;
    logic [DATA_W-1:0] ex_rt;
    logic              ex_pred_taken;
    logic [DATA_W-1:0] ex_pred_target;
    logic [1:0]        pc_src;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
`ifdef BPRED_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_misses;
`endif

    modport master (
        output f_valid, f_pc,
        output ex_valid, ex_pc, ex_op, ex_func, ex_rt_field, ex_index,
        output ex_rs, ex_rt, ex_pred_taken, ex_pred_target,
        input  ready, pred_taken, pred_target,
        input  pc_src, redirect, redirect_pc
`ifdef BPRED_STATS_EN
        , input stat_branches, stat_misses
`endif
    );

    modport slave (
        input  f_valid, f_pc,
        input  ex_valid, ex_pc, ex_op, ex_func, ex_rt_field, ex_index,
        input  ex_rs, ex_rt, ex_pred_taken, ex_pred_target,
        output ready, pred_taken, pred_target,
        output pc_src, redirect, redirect_pc
`ifdef BPRED_STATS_EN
        , output stat_branches, stat_misses
`endif
    );

endinterface

// File: rtl/bpred_branch_cond.sv
// Control-transfer decoder: classifies op/func/rt and evaluates the
// signed branch condition; pc_src is SEQ unless the transfer is taken.
module branch_cond
    import bpred_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op_i,
    input  logic [5:0]        func_i,
    input  logic [4:0]        rt_field_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic              is_ctrl_o,
    output logic              taken_o,
    output logic [1:0]        pc_src_o
);

    logic signed [DATA_W-1:0] rs_s;
    logic                     rs_neg;
    logic                     rs_zero;
    logic                     rgm_ge;
    logic                     rgm_lt;
    logic                     is_jr;
    logic [1:0]               kind;

    assign rs_s    = $signed(rs_i);
    assign rs_neg  = rs_s < 0;
    assign rs_zero = rs_i == '0;
    assign rgm_ge  = (rt_field_i == RT_BGEZ) || (rt_field_i == RT_BGEZAL);
    assign rgm_lt  = (rt_field_i == RT_BLTZ) || (rt_field_i == RT_BLTZAL);
    assign is_jr   = (func_i == FN_JR) || (func_i == FN_JALR);

    // decode the instruction class and its outcome
    always_comb begin
        is_ctrl_o = 1'b0;
        taken_o   = 1'b0;
        kind      = PCSRC_SEQ;
        unique case (1'b1)
            (op_i == OP_BEQ): begin
                is_ctrl_o = 1'b1;
                taken_o   = rs_i == rt_i;
                kind      = PCSRC_BR;
            end
            (op_i == OP_BNE): begin
                is_ctrl_o = 1'b1;
                taken_o   = rs_i != rt_i;
                kind      = PCSRC_BR;
            end
            (op_i == OP_BLEZ): begin
                is_ctrl_o = 1'b1;
                taken_o   = rs_neg | rs_zero;
                kind      = PCSRC_BR;
            end
            (op_i == OP_BGTZ): begin
                is_ctrl_o = 1'b1;
                taken_o   = !rs_neg && !rs_zero;
                kind      = PCSRC_BR;
            end
            (op_i == OP_REGIMM && rgm_ge): begin
                is_ctrl_o = 1'b1;
                taken_o   = !rs_neg;
                kind      = PCSRC_BR;
            end
            (op_i == OP_REGIMM && rgm_lt): begin
                is_ctrl_o = 1'b1;
                taken_o   = rs_neg;
                kind      = PCSRC_BR;
            end
            (op_i == OP_J || op_i == OP_JAL): begin
                is_ctrl_o = 1'b1;
                taken_o   = 1'b1;
                kind      = PCSRC_J;
            end
            (op_i == OP_SPECIAL && is_jr): begin
                is_ctrl_o = 1'b1;
                taken_o   = 1'b1;
                kind      = PCSRC_JR;
            end
            default: ;
        endcase
        pc_src_o = taken_o ? kind : PCSRC_SEQ;
    end

endmodule

// File: rtl/bpred_unit.sv
// Branch prediction table with registered fetch lookup and execute
// resolution. Defining BPRED_STATS_EN adds branch/miss counters.
module bpred_unit
    import bpred_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2
) (
    input  logic   clk,
    input  logic   rst,
    bpred_if.slave bus
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;

    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic              val_q [ENTRIES];
    logic [DATA_W-1:0] tgt_q [ENTRIES];

    logic              is_ctrl;
    logic              taken;
    logic [1:0]        pc_src;

    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] br_tgt;
    logic [DATA_W-1:0] j_tgt;
    logic [DATA_W-1:0] target;
    logic              mispred;

    logic              train_en;
    logic [IDX_W-1:0]  t_idx;
    logic [CTR_W-1:0]  ctr_old;
    logic [CTR_W-1:0]  ctr_new;
    logic              val_new;
    logic [DATA_W-1:0] tgt_new;

    logic [IDX_W-1:0]  f_idx;
    logic              bypass;
    logic [CTR_W-1:0]  rd_ctr;
    logic              rd_val;
    logic [DATA_W-1:0] rd_tgt;

    logic              pred_taken_q, pred_taken_d;
    logic [DATA_W-1:0] pred_target_q, pred_target_d;
    logic [1:0]        pc_src_q, pc_src_d;
    logic              redirect_q, redirect_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

    logic              unused;

    branch_cond #(.DATA_W(DATA_W)) u_cond (
        .op_i       (bus.ex_op),
        .func_i     (bus.ex_func),
        .rt_field_i (bus.ex_rt_field),
        .rs_i       (bus.ex_rs),
        .rt_i       (bus.ex_rt),
        .is_ctrl_o  (is_ctrl),
        .taken_o    (taken),
        .pc_src_o   (pc_src)
    );

    assign unused = ^{bus.f_pc[DATA_W-1:IDX_W+2], bus.f_pc[1:0]};

    // FSM state and sweep index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // INIT clears one entry per cycle, then hands over to RUN
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (&sweep_q) state_d = ST_RUN;
            end
            ST_RUN:  ;
            default: state_d = ST_INIT;
        endcase
    end

    assign pc4     = bus.ex_pc + DATA_W'(4);
    assign imm_ext = {{(DATA_W-16){bus.ex_index[15]}}, bus.ex_index[15:0]};
    assign br_tgt  = pc4 + (imm_ext << 2);
    assign j_tgt   = {pc4[DATA_W-1:28], bus.ex_index, 2'b00};

    // resolved target and mispredict detection
    always_comb begin
        if (pc_src == PCSRC_J)       target = j_tgt;
        else if (pc_src == PCSRC_JR) target = bus.ex_rs;
        else                         target = br_tgt;
        mispred = (taken != bus.ex_pred_taken) ||
                  (taken && bus.ex_pred_taken &&
                   target != bus.ex_pred_target);
    end

    assign train_en = bus.ex_valid && is_ctrl && !rst &&
                      (state_q == ST_RUN);
    assign t_idx    = bus.ex_pc[IDX_W+1:2];
    assign ctr_old  = ctr_q[t_idx];

    // saturating counter step and write-back values
    always_comb begin
        if (taken)
            ctr_new = (ctr_old == CTR_MAX) ? ctr_old : ctr_old + CTR_W'(1);
        else
            ctr_new = (ctr_old == '0) ? ctr_old : ctr_old - CTR_W'(1);
        val_new = taken | val_q[t_idx];
        tgt_new = taken ? target : tgt_q[t_idx];
    end

    // table writes: the clear sweep owns the table during INIT
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            ctr_q[sweep_q] <= CTR_RST;
            val_q[sweep_q] <= 1'b0;
            tgt_q[sweep_q] <= '0;
        end else if (train_en) begin
            ctr_q[t_idx] <= ctr_new;
            val_q[t_idx] <= val_new;
            tgt_q[t_idx] <= tgt_new;
        end
    end

    assign f_idx  = bus.f_pc[IDX_W+1:2];
    assign bypass = train_en && (f_idx == t_idx);
    assign rd_ctr = bypass ? ctr_new : ctr_q[f_idx];
    assign rd_val = bypass ? val_new : val_q[f_idx];
    assign rd_tgt = bypass ? tgt_new : tgt_q[f_idx];

    // next values of the lookup and resolution output registers
    always_comb begin
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        pc_src_d      = PCSRC_SEQ;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (bus.f_valid) begin
            if (state_q == ST_RUN) begin
                pred_taken_d  = rd_val & rd_ctr[CTR_W-1];
                pred_target_d = rd_tgt;
            end else begin
                pred_taken_d  = 1'b0;
                pred_target_d = '0;
            end
        end
        if (bus.ex_valid) begin
            pc_src_d      = pc_src;
            redirect_d    = mispred;
            redirect_pc_d = taken ? target : pc4;
        end
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pc_src_q      <= PCSRC_SEQ;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            pc_src_q      <= pc_src_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.ready       = state_q == ST_RUN;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;
    assign bus.pc_src      = pc_src_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;

`ifdef BPRED_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_miss_q;

    // trained-instruction and redirect counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q   <= '0;
            stat_miss_q <= '0;
        end else begin
            if (train_en) stat_br_q <= stat_br_q + 32'd1;
            if (redirect_d) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign bus.stat_branches = stat_br_q;
    assign bus.stat_misses   = stat_miss_q;
`endif

endmodule

// File: tb/tb_bpred_unit.sv
// Randomized bench for bpred_unit against a table-level reference model.
// Stats checks are compiled in when BPRED_STATS_EN is defined.
module tb_bpred_unit;

    localparam int DW = 32;
    localparam int N  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bpred_if #(.DATA_W(DW)) bif ();

    bpred_unit #(.DATA_W(DW), .IDX_W(6), .CTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int total = 0;
    int bad   = 0;

    // reference model: counters as plain integers 0..3
    int          m_ctr [N];
    bit          m_val [N];
    logic [31:0] m_tgt [N];
    int          m_init;
    bit          e_pt;
    logic [31:0] e_ptgt;
    logic [1:0]  e_pcs;
    bit          e_rd;
    logic [31:0] e_rpc;
    int unsigned m_br;
    int unsigned m_miss;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void resolve(
        input  logic [5:0]  op,
        input  logic [5:0]  fn,
        input  logic [4:0]  rtf,
        input  logic [25:0] idx,
        input  logic [31:0] pc,
        input  logic [31:0] rs,
        input  logic [31:0] rt,
        output bit          ctrl,
        output bit          tk,
        output logic [1:0]  kind,
        output logic [31:0] tgt
    );
        int          srs;
        int          off;
        logic [31:0] pc4;
        srs  = $signed(rs);
        off  = int'($signed(idx[15:0])) * 4;
        pc4  = pc + 32'd4;
        ctrl = 1'b0;
        tk   = 1'b0;
        kind = 2'd0;
        tgt  = pc4 + 32'(off);
        case (op)
            6'h04: begin ctrl = 1; tk = (rs == rt); kind = 2; end
            6'h05: begin ctrl = 1; tk = (rs != rt); kind = 2; end
            6'h06: begin ctrl = 1; tk = (srs <= 0); kind = 2; end
            6'h07: begin ctrl = 1; tk = (srs > 0);  kind = 2; end
            6'h01: begin
                if (rtf == 5'h01 || rtf == 5'h11) begin
                    ctrl = 1; tk = (srs >= 0); kind = 2;
                end else if (rtf == 5'h00 || rtf == 5'h10) begin
                    ctrl = 1; tk = (srs < 0); kind = 2;
                end
            end
            6'h02, 6'h03: begin
                ctrl = 1; tk = 1; kind = 1;
                tgt  = {pc4[31:28], idx, 2'b00};
            end
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin
                    ctrl = 1; tk = 1; kind = 3; tgt = rs;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic step();
        bit          ctrl, tk, miss, run;
        logic [1:0]  kind;
        logic [31:0] tgt;
        int          i;
        if (rst) begin
            m_init = N;
            for (int k = 0; k < N; k++) begin
                m_ctr[k] = 1;
                m_val[k] = 0;
                m_tgt[k] = '0;
            end
            e_pt = 0; e_ptgt = '0; e_pcs = '0; e_rd = 0; e_rpc = '0;
            m_br = 0; m_miss = 0;
        end else begin
            run = (m_init == 0);
            resolve(bif.ex_op, bif.ex_func, bif.ex_rt_field, bif.ex_index,
                    bif.ex_pc, bif.ex_rs, bif.ex_rt, ctrl, tk, kind, tgt);
            if (bif.ex_valid) begin
                miss  = (tk != bif.ex_pred_taken) ||
                        (tk && bif.ex_pred_taken && tgt != bif.ex_pred_target);
                e_pcs = tk ? kind : 2'd0;
                e_rd  = miss;
                e_rpc = tk ? tgt : bif.ex_pc + 32'd4;
                if (miss) m_miss++;
                if (run && ctrl) begin
                    m_br++;
                    i = int'(bif.ex_pc[7:2]);
                    if (tk) begin
                        if (m_ctr[i] < 3) m_ctr[i]++;
                        m_val[i] = 1;
                        m_tgt[i] = tgt;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i]--;
                    end
                end
            end else begin
                e_pcs = '0;
                e_rd  = 0;
            end
            if (bif.f_valid) begin
                if (!run) begin
                    e_pt   = 0;
                    e_ptgt = '0;
                end else begin
                    i      = int'(bif.f_pc[7:2]);
                    e_pt   = m_val[i] && (m_ctr[i] >= 2);
                    e_ptgt = m_tgt[i];
                end
            end
            if (m_init > 0) m_init--;
        end
        @(posedge clk);
        #1;
        chk("ready", bif.ready, m_init == 0);
        chk("pred_taken", bif.pred_taken, e_pt);
        chk("pred_target", bif.pred_target, e_ptgt);
        chk("pc_src", bif.pc_src, e_pcs);
        chk("redirect", bif.redirect, e_rd);
        chk("redirect_pc", bif.redirect_pc, e_rpc);
`ifdef BPRED_STATS_EN
        chk("stat_branches", bif.stat_branches, m_br);
        chk("stat_misses", bif.stat_misses, m_miss);
`endif
    endtask

    task automatic set_ex(bit v, logic [31:0] pc, logic [5:0] op,
                          logic [5:0] fn, logic [4:0] rtf,
                          logic [25:0] idx, logic [31:0] rs,
                          logic [31:0] rt, bit pt, logic [31:0] ptg);
        bif.ex_valid       = v;
        bif.ex_pc          = pc;
        bif.ex_op          = op;
        bif.ex_func        = fn;
        bif.ex_rt_field    = rtf;
        bif.ex_index       = idx;
        bif.ex_rs          = rs;
        bif.ex_rt          = rt;
        bif.ex_pred_taken  = pt;
        bif.ex_pred_target = ptg;
    endtask

    task automatic idle();
        bif.f_valid = 1'b0;
        bif.f_pc    = '0;
        set_ex(0, 0, 6'h08, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd5;
            3: return 32'hFFFF_FFFF;
            4: return 32'h400;
            5: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_in();
        logic [5:0]  ops [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                                  6'h05, 6'h06, 6'h07, 6'h08, 6'h23};
        logic [5:0]  fns [3]  = '{6'h08, 6'h09, 6'h20};
        logic [4:0]  rts [5]  = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h02};
        logic [31:0] pc;
        bit          ctrl, tk;
        logic [1:0]  kind;
        logic [31:0] tgt;
        pc = ($urandom_range(0, 3) == 0) ? {$urandom} & ~32'h3
                                         : 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        set_ex($urandom_range(0, 3) != 0, pc,
               ops[$urandom_range(0, 9)], fns[$urandom_range(0, 2)],
               rts[$urandom_range(0, 4)], 26'($urandom),
               pick_val(), pick_val(), $urandom_range(0, 1) == 1,
               $urandom);
        resolve(bif.ex_op, bif.ex_func, bif.ex_rt_field, bif.ex_index,
                bif.ex_pc, bif.ex_rs, bif.ex_rt, ctrl, tk, kind, tgt);
        if ($urandom_range(0, 1) == 1) bif.ex_pred_target = tgt;
        bif.f_valid = $urandom_range(0, 2) != 0;
        bif.f_pc    = ($urandom_range(0, 2) == 0)
                      ? pc : 32'h1000 + 32'($urandom_range(0, 15)) * 4;
    endtask

    task automatic wait_ready(string tag);
        int cnt;
        cnt = 0;
        while (cnt < 100) begin
            bif.f_valid = $urandom_range(0, 1) == 1;
            bif.f_pc    = 32'($urandom_range(0, 63)) * 4;
            step();
            cnt++;
            if (bif.ready) break;
        end
        chk(tag, cnt, 64);
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_ready", bif.ready, 0);
        chk("rst_redirect", bif.redirect, 0);
        rst = 1'b0;
        wait_ready("init_len");

        for (int i = 0; i < N; i++) begin
            bif.f_valid = 1'b1;
            bif.f_pc    = 32'(i * 4);
            step();
            chk("clr_pt", bif.pred_taken, 0);
        end
        idle();

        set_ex(1, 32'h100, 6'h04, 0, 0, 26'h4, 5, 5, 0, 0);
        step();
        chk("beq_pcsrc", bif.pc_src, 2'b10);
        chk("beq_redirect", bif.redirect, 1);
        chk("beq_rpc", bif.redirect_pc, 32'h114);
        idle();
        step();
        chk("pulse_one", bif.redirect, 0);

        set_ex(1, 32'h180, 6'h01, 0, 5'h01, 26'h10, 32'hFFFF_FFFF, 0, 1,
               32'h1C4);
        step();
        chk("bgez_pcsrc", bif.pc_src, 2'b00);
        chk("bgez_redirect", bif.redirect, 1);
        chk("bgez_rpc", bif.redirect_pc, 32'h184);

        set_ex(1, 32'h200, 6'h05, 0, 0, 26'h8, 1, 2, 0, 0);
        step();
        step();
        idle();
        bif.f_valid = 1'b1;
        bif.f_pc    = 32'h200;
        step();
        chk("bne_pt", bif.pred_taken, 1);
        chk("bne_tgt", bif.pred_target, 32'h224);
        idle();
        set_ex(1, 32'h200, 6'h05, 0, 0, 26'h8, 1, 1, 1, 32'h224);
        step();
        step();
        idle();
        bif.f_valid = 1'b1;
        bif.f_pc    = 32'h200;
        step();
        chk("bne_nt_pt", bif.pred_taken, 0);

        set_ex(1, 32'h300, 6'h00, 6'h08, 0, 0, 32'h400, 0, 1, 32'h500);
        bif.f_valid = 1'b1;
        bif.f_pc    = 32'h300;
        step();
        chk("jr_redirect", bif.redirect, 1);
        chk("jr_rpc", bif.redirect_pc, 32'h400);
        chk("jr_pcsrc", bif.pc_src, 2'b11);
        chk("byp_pt", bif.pred_taken, 1);
        chk("byp_tgt", bif.pred_target, 32'h400);
        idle();
        step();

        for (int it = 0; it < 1500; it++) begin
            rst = (it == 700);
            rand_in();
            step();
        end
        rst = 1'b0;
        idle();
        step();

`ifdef BPRED_STATS_EN
        rst = 1'b1;
        step();
        chk("stat_rst_br", bif.stat_branches, 0);
        chk("stat_rst_miss", bif.stat_misses, 0);
        rst = 1'b0;
        wait_ready("stat_init_len");
        for (int k = 0; k < 10; k++) begin
            set_ex(1, 32'h2000 + 32'(k * 4), 6'h04, 0, 0, 26'h1, 0, 0,
                   k >= 3, 32'h2008 + 32'(k * 4));
            step();
        end
        idle();
        step();
        chk("stat_br10", bif.stat_branches, 10);
        chk("stat_miss3", bif.stat_misses, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
